// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencing ALU stage: single-cycle ops plus iterative shift-add multiply
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             en_acc_in,
    output logic [WIDTH-1:0] alu_result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   product_next;
    logic [CW-1:0]        count;
    logic                 last_step;
    logic [WIDTH:0]       single_res;
    logic                 mul_carry;

    // Single-cycle result: MSB carries the carry/borrow flag.
    always_comb begin
        single_res = '0;
        case (opcode)
            OP_PASS: single_res = {1'b0, acc_in};
            OP_ADD:  single_res = {1'b0, acc_in} + {1'b0, data_in};
            OP_SUB:  single_res = {1'b0, acc_in} - {1'b0, data_in};
            OP_AND:  single_res = {1'b0, acc_in & data_in};
            OP_XOR:  single_res = {1'b0, acc_in ^ data_in};
            OP_LDA:  single_res = {1'b0, data_in};
            OP_SHL:  single_res = {acc_in, 1'b0};
            default: single_res = '0;
        endcase
    end

    // mcand is pre-shifted each step, so it always equals multiplicand << step index.
    always_comb begin
        product_next = product + (mplier[0] ? mcand : '0);
        mul_carry    = |product_next[2*WIDTH-1:WIDTH];
        last_step    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        en_acc_in  = (state == DONE);
        case (state)
            IDLE:    if (start) next_state = (opcode == OP_MUL) ? MULT : DONE;
            MULT:    if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_result <= '0;
            carry      <= 1'b0;
            zero       <= 1'b1;
            mcand      <= '0;
            mplier     <= '0;
            product    <= '0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (opcode == OP_MUL) begin
                            mcand   <= {{WIDTH{1'b0}}, acc_in};
                            mplier  <= data_in;
                            product <= '0;
                            count   <= '0;
                        end else begin
                            alu_result <= single_res[WIDTH-1:0];
                            carry      <= single_res[WIDTH];
                            zero       <= (single_res[WIDTH-1:0] == '0);
                        end
                    end
                end
                MULT: begin
                    product <= product_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count + CW'(1);
                    if (last_step) begin
                        alu_result <= product_next[WIDTH-1:0];
                        carry      <= mul_carry;
                        zero       <= (product_next[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized checks of alu_seq against an arithmetic reference
module tb_alu_seq;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clock;
    logic         reset;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] acc_in;
    logic [W-1:0] data_in;
    logic         busy;
    logic         en_acc_in;
    logic [W-1:0] alu_result;
    logic         carry;
    logic         zero;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .acc_in     (acc_in),
        .data_in    (data_in),
        .busy       (busy),
        .en_acc_in  (en_acc_in),
        .alu_result (alu_result),
        .carry      (carry),
        .zero       (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int op, input int a, input int b,
                                  output int r, output int c);
        int s;
        case (op)
            0: begin r = a;                  c = 0;                 end
            1: begin s = a + b; r = s % M;   c = (s >= M);          end
            2: begin r = (a - b + M) % M;    c = (a < b);           end
            3: begin r = a & b;              c = 0;                 end
            4: begin r = a ^ b;              c = 0;                 end
            5: begin r = b;                  c = 0;                 end
            6: begin s = a * b; r = s % M;   c = (s >= M);          end
            default: begin s = a * 2; r = s % M; c = (a >= M / 2);  end
        endcase
    endfunction

    // Issue one op, verify latency, pulse shape and flags, and that outputs hold afterwards.
    task automatic do_op(input int op, input int a, input int b);
        int er, ec, lat;
        model(op, a, b, er, ec);
        lat = (op == 6) ? W : 0;
        @(negedge clock);
        start = 1'b1; opcode = 3'(op); acc_in = W'(a); data_in = W'(b);
        @(posedge clock); #1;
        start = 1'b0;
        acc_in = W'($urandom_range(M - 1, 0));
        data_in = W'($urandom_range(M - 1, 0));
        for (int i = 0; i < lat; i++) begin
            check("mul_busy", busy, 1);
            check("mul_no_en", en_acc_in, 0);
            @(posedge clock); #1;
        end
        check("done_en", en_acc_in, 1);
        check("done_busy", busy, 1);
        check("result", alu_result, er);
        check("carry", carry, ec);
        check("zero", zero, (er == 0));
        @(posedge clock); #1;
        check("idle_en", en_acc_in, 0);
        check("idle_busy", busy, 0);
        check("hold_result", alu_result, er);
    endtask

    initial begin
        int seen_en;
        reset = 1'b1; start = 1'b0; opcode = '0; acc_in = '0; data_in = '0;
        #2;
        check("rst_result", alu_result, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        check("rst_en", en_acc_in, 0);
        @(negedge clock); reset = 1'b0;

        do_op(1, 8'hF0, 8'h20);
        check("add_const", alu_result, 8'h10);
        check("add_carry_const", carry, 1);

        // Mid-cycle asynchronous reset clears a non-zero result with no clock edge.
        @(negedge clock); #2; reset = 1'b1; #1;
        check("arst_result", alu_result, 0);
        check("arst_zero", zero, 1);
        check("arst_carry", carry, 0);
        @(negedge clock); reset = 1'b0;

        do_op(2, 8'h05, 8'h05);
        check("sub_eq_zero", zero, 1);
        do_op(2, 8'h03, 8'h05);
        check("sub_borrow_const", alu_result, 8'hFE);

        // Start held through DONE: ignored in DONE, re-accepted two edges later.
        @(negedge clock);
        start = 1'b1; opcode = 3'd2; acc_in = 8'h09; data_in = 8'h01;
        @(posedge clock); #1;
        check("hold_first_en", en_acc_in, 1);
        check("hold_first_res", alu_result, 8'h08);
        acc_in = 8'h20; data_in = 8'h01;
        @(posedge clock); #1;
        check("hold_done_ignored_en", en_acc_in, 0);
        check("hold_done_ignored_busy", busy, 0);
        check("hold_done_res", alu_result, 8'h08);
        @(posedge clock); #1;
        start = 1'b0;
        check("hold_second_en", en_acc_in, 1);
        check("hold_second_res", alu_result, 8'h1F);
        @(posedge clock); #1;

        do_op(6, 8'h0D, 8'h0B);
        check("mul_const", alu_result, 8'h8F);
        do_op(6, 8'h10, 8'h10);
        check("mul_ovf_carry", carry, 1);
        check("mul_ovf_zero", zero, 1);

        // ADD requests every cycle during a MUL are dropped until IDLE.
        @(negedge clock);
        start = 1'b1; opcode = 3'd6; acc_in = 8'h03; data_in = 8'h05;
        @(posedge clock); #1;
        opcode = 3'd1; acc_in = 8'h11; data_in = 8'h22;
        for (int i = 1; i <= W; i++) begin
            @(posedge clock); #1;
            if (i < W) check("spam_no_en", en_acc_in, 0);
        end
        check("spam_mul_en", en_acc_in, 1);
        check("spam_mul_res", alu_result, 8'h0F);
        @(posedge clock); #1;
        check("spam_gap_en", en_acc_in, 0);
        check("spam_gap_res", alu_result, 8'h0F);
        @(posedge clock); #1;
        start = 1'b0;
        check("spam_add_en", en_acc_in, 1);
        check("spam_add_res", alu_result, 8'h33);
        @(posedge clock); #1;

        // Reset during MUL step 4 abandons the multiply without a pulse.
        @(negedge clock);
        start = 1'b1; opcode = 3'd6; acc_in = 8'hFF; data_in = 8'hFF;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2; reset = 1'b1; #1;
        check("mulrst_result", alu_result, 0);
        check("mulrst_busy", busy, 0);
        check("mulrst_en", en_acc_in, 0);
        @(posedge clock); @(negedge clock); reset = 1'b0;
        seen_en = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (en_acc_in !== 1'b0) seen_en++;
        end
        check("mulrst_no_pulse", seen_en, 0);
        do_op(7, 8'h81, 8'h00);
        check("shl_const", alu_result, 8'h02);
        check("shl_carry_const", carry, 1);

        for (int n = 0; n < 40; n++) begin
            do_op(int'($urandom_range(7, 0)), int'($urandom_range(M - 1, 0)),
                  int'($urandom_range(M - 1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing ALU stage feeding the accumulator. It accepts a start request with an opcode and two 8-bit operands: the current accumulator value and a data-bus byte. It runs single-cycle or iterative (shift-add multiply) operations and delivers a registered result together with a one-cycle write-enable pulse. That pulse drives the accumulator's `en_acc_in`, and `alu_result` connects directly to the accumulator's data input.

## Interface
- `WIDTH`, default 8: operand/result width; iteration count of MUL equals `WIDTH`.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `opcode`  in  3  operation select, sampled with `start`.
- `acc_in`  in  WIDTH  accumulator value (from `acc_out`), sampled with `start`.
- `data_in`  in  WIDTH  data-bus operand, sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `en_acc_in`  out  1  one-cycle pulse: `alu_result` valid, accumulator must load.
- `alu_result`  out  WIDTH  registered result, held until next completion.
- `carry`  out  1  registered carry/borrow/overflow flag, updated with result.
- `zero`  out  1  registered flag, `alu_result == 0`, updated with result.

## Operation
- Opcodes:
  - 000 PASS: result = acc, carry = 0.
  - 001 ADD: {carry, result} = acc + data.
  - 010 SUB: result = acc − data mod 2^WIDTH; carry = borrow (acc < data).
  - 011 AND: result = acc & data, carry = 0.
  - 100 XOR: result = acc ^ data, carry = 0.
  - 101 LDA: result = data, carry = 0.
  - 110 MUL: unsigned acc × data. Result = low WIDTH bits of the 2·WIDTH product; carry = OR of the high WIDTH bits.
  - 111 SHL: result = acc << 1, carry = acc[WIDTH−1].
- FSM states:
  - IDLE: `start` = 1 with a single-cycle opcode → compute, register result/flags, go to DONE. `start` = 1 with MUL → capture multiplicand = acc, multiplier = data, clear the 2·WIDTH product and step counter, go to MULT. `start` = 0 → stay in IDLE.
  - MULT: each cycle, if multiplier LSB = 1, add multiplicand (shifted left by the step index) into the product. Then shift the multiplier right and increment the counter. After the WIDTH-th step, register result/flags and go to DONE.
  - DONE: `en_acc_in` = 1 for exactly this cycle; next state is IDLE unconditionally.
- `start` is ignored in MULT and DONE. No queuing; the request is dropped.
- Operands are captured at the accepting edge. Later changes to `acc_in`/`data_in` do not affect the operation in flight.
- `alu_result`, `carry` and `zero` change only on the edge entering DONE. They hold otherwise, including through IDLE.
- Reset (asynchronous, any state, including mid-MULT): state → IDLE, `alu_result` = 0, `carry` = 0, `zero` = 1, `en_acc_in` = 0, `busy` = 0, multiply registers cleared. An in-flight operation is abandoned with no enable pulse.

## Timing
- Single-cycle op accepted at edge k: result/flags valid and `en_acc_in` = 1 during cycle k→k+1. The accumulator loads at edge k+1. `busy` = 1 during k→k+1.
- MUL accepted at edge k: MULT occupies edges k+1…k+WIDTH; the last step completes at edge k+WIDTH. DONE and the enable pulse follow during cycle k+WIDTH→k+WIDTH+1. `busy` is high for WIDTH+1 cycles.
- Minimum start-to-start spacing is 2 cycles for single-cycle ops and WIDTH+2 for MUL. A start sampled at edge k+1 (the DONE cycle) is ignored. The earliest accepted next start is edge k+2, where `acc_in` already reflects the new accumulator value.
- `en_acc_in` is never high on two consecutive cycles.

## Test plan
- Reset: assert `reset` mid-cycle with no clock edge → immediately `alu_result` = 0x00, `carry` = 0, `zero` = 1, `busy` = 0, `en_acc_in` = 0.
- ADD acc = 0xF0, data = 0x20, start at edge k → during k→k+1: `alu_result` = 0x10, `carry` = 1, `zero` = 0, `en_acc_in` = 1 for one cycle only.
- SUB:
  - 0x05 − 0x05 → 0x00, `zero` = 1, `carry` = 0.
  - 0x03 − 0x05 → 0xFE, `carry` = 1.
  - Start held high through DONE → second start ignored; re-accepted at k+2.
- MUL:
  - 0x0D × 0x0B → `alu_result` = 0x8F, `carry` = 0. `busy` high 9 cycles; `en_acc_in` in cycle k+8→k+9.
  - 0x10 × 0x10 → `alu_result` = 0x00, `carry` = 1, `zero` = 1.
- `start` with ADD asserted every cycle during a MUL → ignored; the MUL result is unchanged; the first ADD is accepted only after DONE returns to IDLE.
- `reset` pulsed at MUL step 4 → outputs cleared, no `en_acc_in` pulse. After release, SHL acc = 0x81 → 0x02, `carry` = 1, normal latency.
